// File: rtl/n64_controller_responder.sv
// N64 controller-side responder: decodes console command frames on a single-wire line
// and replies with identify data or latched button state.
module n64_controller_responder #(
    parameter int          CLKS_PER_US    = 4,
    parameter logic [15:0] DEVICE_ID      = 16'h0500,
    parameter logic [7:0]  STATUS_BYTE    = 8'h02,
    parameter int          REPLY_DELAY_US = 2
) (
    input  logic        sample_clk,
    input  logic        reset,
    input  logic        data_rx,
    input  logic [31:0] buttons,
    output logic        data_tx,
    output logic [7:0]  cmd,
    output logic        cmd_valid,
    output logic        rx_error,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    localparam int U    = CLKS_PER_US;
    localparam int DLY  = REPLY_DELAY_US * U;
    localparam int CMAX = (6 * U > DLY) ? 6 * U : DLY;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] C_U        = CW'(U);
    localparam logic [CW-1:0] C_3U       = CW'(3 * U);
    localparam logic [CW-1:0] C_SAMPLE   = CW'(2 * U - 1);
    localparam logic [CW-1:0] C_TIMEOUT  = CW'(6 * U - 1);
    localparam logic [CW-1:0] C_BIT_END  = CW'(4 * U - 1);
    localparam logic [CW-1:0] C_STOP_END = CW'(2 * U - 1);
    localparam logic [CW-1:0] C_DLY_END  = CW'(DLY - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RX_BIT     = 3'd1,
        S_TURNAROUND = 3'd2,
        S_TX_BIT     = 3'd3,
        S_TX_STOP    = 3'd4,
        S_GUARD      = 3'd5,
        S_WAIT_IDLE  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic          prev_q;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [4:0]    bit_q, bit_d;
    logic [4:0]    last_q, last_d;
    logic [7:0]    shift_q, shift_d;
    logic [31:0]   reply_q, reply_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          rx_error_q, rx_error_d;
    logic          data_tx_q, data_tx_d;
    logic          busy_q, busy_d;

    logic synced, fall;
    assign synced = sync_q[1];
    assign fall   = prev_q & ~synced;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        bit_d       = bit_q;
        last_d      = last_q;
        shift_d     = shift_q;
        reply_d     = reply_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        rx_error_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_RX_BIT;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end
            S_RX_BIT: begin
                if (fall) begin
                    bit_d = bit_q + 5'd1;
                    cyc_d = '0;
                end else if (cyc_q == C_SAMPLE) begin
                    cyc_d = cyc_q + 1'b1;
                    if (bit_q < 5'd8) begin
                        shift_d = {shift_q[6:0], synced};
                    end else if (synced && (shift_q == 8'h00 || shift_q == 8'h01 || shift_q == 8'hFF)) begin
                        cmd_d       = shift_q;
                        cmd_valid_d = 1'b1;
                        state_d     = S_TURNAROUND;
                        cyc_d       = '0;
                        bit_d       = '0;
                        // Reply is left-aligned so the MSB is always the bit on the wire.
                        if (shift_q == 8'h01) begin
                            reply_d = buttons;
                            last_d  = 5'd31;
                        end else begin
                            reply_d = {DEVICE_ID, STATUS_BYTE, 8'h00};
                            last_d  = 5'd23;
                        end
                    end else begin
                        rx_error_d = 1'b1;
                        state_d    = S_WAIT_IDLE;
                        cyc_d      = '0;
                    end
                end else if (cyc_q == C_TIMEOUT) begin
                    rx_error_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_TURNAROUND: begin
                if (cyc_q == C_DLY_END) begin
                    state_d = S_TX_BIT;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_TX_BIT: begin
                if (cyc_q == C_BIT_END) begin
                    cyc_d = '0;
                    if (bit_q == last_q) begin
                        state_d = S_TX_STOP;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        reply_d = {reply_q[30:0], 1'b0};
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_TX_STOP: begin
                if (cyc_q == C_STOP_END) begin
                    state_d = S_GUARD;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_GUARD: begin
                if (cyc_q == C_STOP_END) begin
                    state_d = S_IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (!synced) begin
                    cyc_d = '0;
                end else if (cyc_q == C_TIMEOUT) begin
                    state_d = S_IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is derived from next-state so data_tx lines up exactly with the state timing.
        data_tx_d = 1'b1;
        if (state_d == S_TX_BIT) begin
            data_tx_d = (cyc_d >= (reply_d[31] ? C_U : C_3U));
        end else if (state_d == S_TX_STOP) begin
            data_tx_d = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            prev_q      <= 1'b1;
            cyc_q       <= '0;
            bit_q       <= '0;
            last_q      <= '0;
            shift_q     <= '0;
            reply_q     <= '0;
            cmd_q       <= 8'h00;
            cmd_valid_q <= 1'b0;
            rx_error_q  <= 1'b0;
            data_tx_q   <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], data_rx};
            prev_q      <= sync_q[1];
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            last_q      <= last_d;
            shift_q     <= shift_d;
            reply_q     <= reply_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            rx_error_q  <= rx_error_d;
            data_tx_q   <= data_tx_d;
            busy_q      <= busy_d;
        end
    end

    assign data_tx   = data_tx_q;
    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign rx_error  = rx_error_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_n64_controller_responder.sv
// Bench for n64_controller_responder: a console driver issues frames, and monitors
// decode the reply line and event pulses against expected queues.
module tb_n64_controller_responder;

    localparam int U = 4;

    logic        sample_clk = 1'b0;
    logic        reset      = 1'b1;
    logic        data_rx    = 1'b1;
    logic [31:0] buttons    = 32'h0;
    logic        data_tx;
    logic [7:0]  cmd;
    logic        cmd_valid;
    logic        rx_error;
    logic        busy;
    logic [2:0]  state_dbg;

    n64_controller_responder #(
        .CLKS_PER_US(U), .DEVICE_ID(16'h0500), .STATUS_BYTE(8'h02), .REPLY_DELAY_US(2)
    ) dut (
        .sample_clk(sample_clk), .reset(reset), .data_rx(data_rx), .buttons(buttons),
        .data_tx(data_tx), .cmd(cmd), .cmd_valid(cmd_valid), .rx_error(rx_error),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 sample_clk = ~sample_clk;

    int cyc_n = 0;
    always @(posedge sample_clk) cyc_n <= cyc_n + 1;

    int checks = 0;
    int failures = 0;

    logic [39:0] exp_q[$];   // {reply bit count, right-aligned reply word}
    logic [8:0]  ev_q[$];    // {is_error, cmd value seen with the pulse}

    int          low_run = 0;
    int          rx_bits = 0;
    logic [31:0] rx_word = 0;
    logic        prev_tx = 1'b1;
    logic        prev_busy = 1'b0;
    int          cv_cyc = 0;
    bit          cv_pending = 0;
    int          stop_end_cyc = 0;
    bit          stop_pending = 0;
    int          tx_low_total = 0;
    int          last_fall_cyc = 0;
    int          last_rise_cyc = 0;
    bit          err_timing_pending = 0;
    bit          idle_timing_pending = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        checks++;
        if (v < lo || v > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    // Reply line decoder and event monitor.
    always @(negedge sample_clk) begin
        if (reset) begin
            low_run = 0; rx_bits = 0; rx_word = 0; prev_tx = 1'b1; prev_busy = 1'b0;
            cv_pending = 0; stop_pending = 0;
        end else begin
            if (cmd_valid || rx_error) begin
                if (ev_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_event: got err=%0b cmd=%0h expected none", rx_error, cmd);
                end else begin
                    check("event_err_cmd", {rx_error, cmd}, ev_q.pop_front());
                end
                if (cmd_valid) begin cv_cyc = cyc_n; cv_pending = 1; end
                if (rx_error && err_timing_pending) begin
                    check_range("timeout_latency", cyc_n - last_fall_cyc, 24, 28);
                    check("timeout_busy", busy, 0);
                    err_timing_pending = 0;
                end
            end
            if (!data_tx) begin
                tx_low_total++;
                low_run++;
                if (prev_tx && cv_pending) begin
                    check("turnaround_cycles", cyc_n - cv_cyc, 8);
                    cv_pending = 0;
                end
            end else if (!prev_tx) begin
                if (low_run == U) begin
                    rx_word = {rx_word[30:0], 1'b1}; rx_bits++;
                end else if (low_run == 3 * U) begin
                    rx_word = {rx_word[30:0], 1'b0}; rx_bits++;
                end else if (low_run == 2 * U) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_reply: got %0d bits %0h expected none", rx_bits, rx_word);
                    end else begin
                        check("reply_len_word", {8'(rx_bits), rx_word}, exp_q.pop_front());
                    end
                    rx_bits = 0; rx_word = 0;
                    stop_end_cyc = cyc_n; stop_pending = 1;
                end else begin
                    checks++; failures++;
                    $display("FAIL pulse_width: got %0d low cycles expected 4, 12 or 8", low_run);
                end
                low_run = 0;
            end
            if (prev_busy && !busy) begin
                if (stop_pending) begin
                    check("busy_after_stop", cyc_n - stop_end_cyc, 8);
                    stop_pending = 0;
                end
                if (idle_timing_pending) begin
                    check_range("wait_idle_latency", cyc_n - last_rise_cyc, 24, 28);
                    idle_timing_pending = 0;
                end
            end
            prev_tx = data_tx;
            prev_busy = busy;
        end
    end

    task automatic send_bit(input logic b);
        data_rx = 1'b0;
        last_fall_cyc = cyc_n;
        repeat (b ? U : 3 * U) @(negedge sample_clk);
        data_rx = 1'b1;
        last_rise_cyc = cyc_n;
        repeat (b ? 3 * U : U) @(negedge sample_clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [7:0] v);
        send_byte(v);
        send_bit(1'b1);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0 || ev_q.size() != 0) && n < 2000) begin
            @(negedge sample_clk);
            n++;
        end
        check("settle_within_budget", (n < 2000), 1);
        repeat (6) @(negedge sample_clk);
    endtask

    initial begin
        int n;
        logic [31:0] v;
        int low_before;

        repeat (3) @(negedge sample_clk);
        check("reset_data_tx", data_tx, 1);
        check("reset_cmd", cmd, 8'h00);
        check("reset_cmd_valid", cmd_valid, 0);
        check("reset_rx_error", rx_error, 0);
        check("reset_busy", busy, 0);
        check("reset_state", state_dbg, 3'd0);
        reset = 1'b0;
        repeat (5) @(negedge sample_clk);

        // Button poll with distinctive edge bits.
        buttons = 32'h8000_00FF;
        ev_q.push_back({1'b0, 8'h01});
        exp_q.push_back({8'd32, 32'h8000_00FF});
        send_frame(8'h01);
        wait_quiet();
        check("cmd_after_01", cmd, 8'h01);

        // Identify via 0xFF.
        ev_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({8'd24, 32'h0005_0002});
        send_frame(8'hFF);
        wait_quiet();
        check("cmd_after_ff", cmd, 8'hFF);

        // Unsupported command with address bits: error, no reply.
        ev_q.push_back({1'b1, 8'hFF});
        idle_timing_pending = 1;
        low_before = tx_low_total;
        send_byte(8'h02);
        send_byte(8'hA5);
        send_byte(8'hF0);
        send_bit(1'b1);
        wait_quiet();
        check("no_reply_on_02", tx_low_total - low_before, 0);
        check("wait_idle_reached", idle_timing_pending, 0);
        check("cmd_after_02", cmd, 8'hFF);

        // Truncated frame: 4 bits then idle line.
        ev_q.push_back({1'b1, 8'hFF});
        err_timing_pending = 1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        wait_quiet();
        check("timeout_seen", err_timing_pending, 0);
        check("cmd_after_timeout", cmd, 8'hFF);

        // Buttons churn during the reply; reply must carry the latched value.
        v = 32'hA5C3_0F96;
        buttons = v;
        ev_q.push_back({1'b0, 8'h01});
        exp_q.push_back({8'd32, v});
        send_frame(8'h01);
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            @(negedge sample_clk);
            buttons = ~buttons;
            n++;
        end
        check("toggle_settle", (n < 2000), 1);
        repeat (6) @(negedge sample_clk);

        // Reset during the 10th reply bit.
        buttons = 32'h1234_5678;
        ev_q.push_back({1'b0, 8'h01});
        send_frame(8'h01);
        n = 0;
        while (!(rx_bits == 9 && !data_tx) && n < 2000) begin
            @(negedge sample_clk);
            n++;
        end
        check("reached_bit10", (n < 2000), 1);
        @(negedge sample_clk);
        #2 reset = 1'b1;
        #1;
        check("reset_mid_reply_data_tx", data_tx, 1);
        check("reset_mid_reply_busy", busy, 0);
        check("reset_mid_reply_cmd", cmd, 8'h00);
        @(negedge sample_clk);
        @(negedge sample_clk);
        reset = 1'b0;
        repeat (4) @(negedge sample_clk);

        ev_q.push_back({1'b0, 8'h00});
        exp_q.push_back({8'd24, 32'h0005_0002});
        send_frame(8'h00);
        wait_quiet();
        check("cmd_after_00", cmd, 8'h00);

        check("exp_q_drained", exp_q.size(), 0);
        check("ev_q_drained", ev_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
